// File: rtl/layer_serializer.sv
// Parallel-to-serial stage between two fully-connected layers: captures one
// activation per neuron in a single cycle and replays them as a valid-qualified stream.
module layer_serializer #(
  parameter int unsigned NN        = 30,
  parameter int unsigned dataWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           i_valid,
  input  logic [NN*dataWidth-1:0] i_data,
  output logic                    o_valid,
  output logic [dataWidth-1:0]    o_data,
  output logic                    o_last,
  output logic                    busy,
  output logic                    err_overrun,
  output logic                    err_partial
);

  localparam int unsigned CW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [CW-1:0] LAST_IDX     = CW'(NN - 1);
  localparam logic [CW-1:0] PRE_LAST_IDX = CW'(NN - 2);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state;
  logic [CW-1:0]        count;
  logic [dataWidth-1:0] shift_buf [NN];

  logic capture;
  logic partial;
  logic last_word;
  logic load;

  assign capture   = &i_valid;
  assign partial   = (|i_valid) & ~capture;
  assign last_word = (state == SHIFT) && (count == LAST_IDX);
  // A new vector is accepted when idle or in the final word cycle (back-to-back).
  assign load      = capture && ((state == IDLE) || last_word);

  // Word 0 goes straight to o_data on load; entry 1 always holds the next word to emit.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < NN; k++) begin
        shift_buf[k] <= i_data[k*dataWidth +: dataWidth];
      end
    end else if (state == SHIFT) begin
      for (int k = 0; k < NN - 1; k++) begin
        shift_buf[k] <= shift_buf[k+1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      count       <= '0;
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_last      <= 1'b0;
      busy        <= 1'b0;
      err_overrun <= 1'b0;
      err_partial <= 1'b0;
    end else begin
      if (partial) begin
        err_partial <= 1'b1;
      end
      // A full vector arriving mid-emission is dropped; the current one continues.
      if (capture && (state == SHIFT) && !last_word) begin
        err_overrun <= 1'b1;
      end

      if (load) begin
        state   <= SHIFT;
        count   <= '0;
        o_valid <= 1'b1;
        o_data  <= i_data[dataWidth-1:0];
        o_last  <= 1'b0;
        busy    <= 1'b1;
      end else if (state == SHIFT) begin
        if (last_word) begin
          state   <= IDLE;
          count   <= '0;
          o_valid <= 1'b0;
          o_last  <= 1'b0;
          busy    <= 1'b0;
        end else begin
          count   <= count + CW'(1);
          o_valid <= 1'b1;
          o_data  <= shift_buf[1];
          o_last  <= (count == PRE_LAST_IDX);
          busy    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_layer_serializer.sv
// Scoreboard bench for layer_serializer: a transaction-level model predicts the
// word stream and sticky flags; a negedge monitor compares every cycle.
module tb_layer_serializer;

  localparam int unsigned DW  = 16;
  localparam int unsigned NA  = 4;
  localparam int unsigned NB  = 30;
  localparam int          BIG = 1 << 30;

  logic clk = 1'b0;
  logic rst;

  logic [NA-1:0]    va;
  logic [NA*DW-1:0] da;
  logic             ova, ola, busya, eoa, epa;
  logic [DW-1:0]    oda;

  logic [NB-1:0]    vb;
  logic [NB*DW-1:0] db;
  logic             ovb, olb, busyb, eob, epb;
  logic [DW-1:0]    odb;

  always #5 clk = ~clk;

  layer_serializer #(.NN(NA), .dataWidth(DW)) u_small (
    .clk(clk), .rst(rst), .i_valid(va), .i_data(da),
    .o_valid(ova), .o_data(oda), .o_last(ola), .busy(busya),
    .err_overrun(eoa), .err_partial(epa)
  );

  layer_serializer #(.NN(NB), .dataWidth(DW)) u_full (
    .clk(clk), .rst(rst), .i_valid(vb), .i_data(db),
    .o_valid(ovb), .o_data(odb), .o_last(olb), .busy(busyb),
    .err_overrun(eob), .err_partial(epb)
  );

  // Observed instance selected by sel; the other one is held idle.
  logic          sel;
  int            nn;
  logic          m_valid, m_last, m_busy, m_eo, m_ep;
  logic [DW-1:0] m_data;

  always_comb begin
    m_valid = sel ? ovb   : ova;
    m_data  = sel ? odb   : oda;
    m_last  = sel ? olb   : ola;
    m_busy  = sel ? busyb : busya;
    m_eo    = sel ? eob   : eoa;
    m_ep    = sel ? epb   : epa;
  end

  typedef struct {
    int            e;
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] words[NB];
  int            edge_n = 0;
  int            last_acc;
  int            ovr_edge;
  int            part_edge;
  logic [DW-1:0] hold;
  logic          in_reset;
  int            checks = 0;
  int            errors = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  // Monitor: compares every cycle against the scoreboard front.
  always @(negedge clk) begin : mon
    exp_t f;
    logic ev;
    if (!in_reset) begin
      ev = (q.size() > 0) && (q[0].e == edge_n);
      chk("o_valid", 32'(m_valid), 32'(ev));
      chk("busy", 32'(m_busy), 32'(ev));
      if (ev) begin
        f = q.pop_front();
        chk("o_data", 32'(m_data), 32'(f.d));
        chk("o_last", 32'(m_last), 32'(f.l));
        hold = f.d;
      end else begin
        chk("o_data_hold", 32'(m_data), 32'(hold));
      end
      chk("err_overrun", 32'(m_eo), 32'(edge_n >= ovr_edge));
      chk("err_partial", 32'(m_ep), 32'(edge_n >= part_edge));
    end
  end

  // One cycle of stimulus; the model decides the fate of the pulse at edge c.
  task automatic step(input logic [NB-1:0] v);
    logic [NB-1:0] fm;
    logic [NB-1:0] vm;
    int            c;
    @(posedge clk);
    #1;
    c  = edge_n + 1;
    fm = {NB{1'b1}} >> (NB - nn);
    vm = v & fm;
    va = '0;
    vb = '0;
    if (sel) begin
      vb = vm;
      for (int k = 0; k < NB; k++) db[k*DW +: DW] = words[k];
    end else begin
      va = vm[NA-1:0];
      for (int k = 0; k < NA; k++) da[k*DW +: DW] = words[k];
    end
    if (vm == fm) begin
      if (c >= last_acc + nn) begin
        for (int k = 0; k < nn; k++) q.push_back('{e: c + k, d: words[k], l: (k == nn - 1)});
        last_acc = c;
      end else if (ovr_edge == BIG) begin
        ovr_edge = c;
      end
    end else if (vm != '0 && part_edge == BIG) begin
      part_edge = c;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0);
  endtask

  task automatic fill_rand();
    for (int k = 0; k < NB; k++) words[k] = DW'($urandom);
  endtask

  function automatic logic [NB-1:0] rand_v();
    logic [NB-1:0] fm;
    logic [NB-1:0] v;
    int            r;
    fm = {NB{1'b1}} >> (NB - nn);
    r  = $urandom_range(0, 9);
    if (r < 3) begin
      v = fm;
    end else if (r == 3) begin
      v = NB'({$urandom, $urandom}) & fm;
      if (v == '0) v = NB'(1);
      if (v == fm) v[0] = 1'b0;
    end else begin
      v = '0;
    end
    return v;
  endfunction

  // Asynchronous reset asserted between edges; outputs must clear immediately.
  task automatic do_reset();
    @(negedge clk);
    #2;
    in_reset = 1'b1;
    rst = 1'b0;
    va = '0;
    vb = '0;
    #1;
    chk("reset_outputs_small", 32'({ova, oda, ola, busya, eoa, epa}), 32'(0));
    chk("reset_outputs_full", 32'({ovb, odb, olb, busyb, eob, epb}), 32'(0));
    q.delete();
    ovr_edge  = BIG;
    part_edge = BIG;
    last_acc  = -BIG;
    hold      = '0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    in_reset = 1'b0;
  endtask

  initial begin
    in_reset = 1'b1;
    rst = 1'b1;
    sel = 1'b0;
    nn  = NA;
    va  = '0;
    da  = '0;
    vb  = '0;
    db  = '0;
    for (int k = 0; k < NB; k++) words[k] = '0;
    do_reset();

    // Basic vector
    for (int k = 0; k < NA; k++) words[k] = DW'(k + 1);
    step('1);
    idle(6);

    // Back-to-back: second pulse in the o_last cycle
    step('1);
    idle(3);
    for (int k = 0; k < NA; k++) words[k] = DW'(16'h00A0 + k);
    step('1);
    idle(8);

    // Overrun two cycles after capture
    for (int k = 0; k < NA; k++) words[k] = DW'(k + 1);
    step('1);
    step('0);
    fill_rand();
    step('1);
    idle(6);

    // Partial in IDLE, then a good vector
    do_reset();
    step(NB'(4'b0101));
    idle(2);
    fill_rand();
    step('1);
    idle(6);

    // Reset mid-vector, then quiet, then a fresh vector
    fill_rand();
    step('1);
    step('0);
    do_reset();
    idle(5);
    fill_rand();
    step('1);
    idle(6);

    // Overrun one cycle before the last-word edge
    do_reset();
    step('1);
    idle(2);
    step('1);
    idle(6);

    // Random stream on the small instance
    do_reset();
    for (int i = 0; i < 80; i++) begin
      fill_rand();
      step(rand_v());
    end
    idle(8);

    // Default parameters with corner words
    do_reset();
    sel = 1'b1;
    nn  = NB;
    fill_rand();
    words[0]  = 16'h8000;
    words[13] = 16'h0000;
    words[NB-1] = 16'hFFFF;
    step('1);
    idle(NB + 4);
    for (int i = 0; i < 200; i++) begin
      fill_rand();
      if (i % 17 == 0) words[i % NB] = 16'h8000;
      step(rand_v());
    end
    idle(NB + 4);

    chk("queue_drained", 32'(q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
